// File: rtl/ariane_cfg_pkg.sv
// rtl/ariane_cfg_pkg.sv - PMA region configuration type and default table
package ariane_cfg_pkg;

  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned                    NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]    NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]    NonIdempotentLength;
    int unsigned                    NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]    ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]    ExecuteRegionLength;
    int unsigned                    NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]    CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]    CachedRegionLength;
  } ariane_cfg_t;

  // Debug, boot ROM and DRAM are executable; only DRAM is cached; the
  // two non-idempotent rules are present but zero-length.
  function automatic ariane_cfg_t default_cfg();
    ariane_cfg_t c;
    c = '0;
    c.NrNonIdempotentRules     = 2;
    c.NrExecuteRegionRules     = 3;
    c.ExecuteRegionAddrBase[0] = 64'h0000_0000;
    c.ExecuteRegionLength[0]   = 64'h0000_1000;
    c.ExecuteRegionAddrBase[1] = 64'h0001_0000;
    c.ExecuteRegionLength[1]   = 64'h0001_0000;
    c.ExecuteRegionAddrBase[2] = 64'h8000_0000;
    c.ExecuteRegionLength[2]   = 64'h4000_0000;
    c.NrCachedRegionRules      = 1;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    return c;
  endfunction

  localparam ariane_cfg_t ArianeDefaultConfig = default_cfg();

endpackage

// File: rtl/pma_scan_unit.sv
// rtl/pma_scan_unit.sv - sequential PMA attribute lookup, one rule index per cycle
module pma_scan_unit #(
  parameter ariane_cfg_pkg::ariane_cfg_t Cfg     = ariane_cfg_pkg::ArianeDefaultConfig,
  parameter int unsigned                 IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [63:0]        req_paddr_i,
  input  logic               req_is_fetch_i,
  input  logic [IdWidth-1:0] req_id_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [63:0]        rsp_paddr_o,
  output logic [IdWidth-1:0] rsp_id_o,
  output logic               rsp_cacheable_o,
  output logic               rsp_nonidem_o,
  output logic               rsp_exec_o,
  output logic               rsp_fault_o
);

  localparam int unsigned NrMaxRules = ariane_cfg_pkg::NrMaxRules;
  localparam int unsigned IdxW       = $clog2(NrMaxRules);
  localparam int unsigned NrNi       = Cfg.NrNonIdempotentRules;
  localparam int unsigned NrEx       = Cfg.NrExecuteRegionRules;
  localparam int unsigned NrCa       = Cfg.NrCachedRegionRules;
  localparam int unsigned MaxNiEx    = (NrNi > NrEx) ? NrNi : NrEx;
  localparam int unsigned MaxAll     = (MaxNiEx > NrCa) ? MaxNiEx : NrCa;
  localparam int unsigned ScanLen    = (MaxAll > 0) ? MaxAll : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ScanLen - 1);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [63:0]         paddr_q, paddr_d;
  logic                is_fetch_q, is_fetch_d;
  logic [IdWidth-1:0]  id_q, id_d;
  logic                nonidem_q, nonidem_d;
  logic                exec_q, exec_d;
  logic                cache_q, cache_d;
  logic                fault_q, fault_d;

  logic hit_nonidem, hit_exec, hit_cache;
  logic accept;

  // End address wraps mod 2^64, so wrapping or zero-length regions never match.
  function automatic logic in_region(input logic [63:0] addr, input logic [63:0] base,
                                     input logic [63:0] len);
    logic [63:0] lim;
    lim = base + len;
    return (addr >= base) && (addr < lim);
  endfunction

  always_comb begin
    hit_nonidem = (32'(idx_q) < NrNi) &&
                  in_region(paddr_q, Cfg.NonIdempotentAddrBase[idx_q], Cfg.NonIdempotentLength[idx_q]);
    hit_exec    = (32'(idx_q) < NrEx) &&
                  in_region(paddr_q, Cfg.ExecuteRegionAddrBase[idx_q], Cfg.ExecuteRegionLength[idx_q]);
    hit_cache   = (32'(idx_q) < NrCa) &&
                  in_region(paddr_q, Cfg.CachedRegionAddrBase[idx_q], Cfg.CachedRegionLength[idx_q]);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    paddr_d     = paddr_q;
    is_fetch_d  = is_fetch_q;
    id_d        = id_q;
    nonidem_d   = nonidem_q;
    exec_d      = exec_q;
    cache_d     = cache_q;
    fault_d     = fault_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        accept      = req_valid_i;
      end
      SCAN: begin
        nonidem_d = nonidem_q | hit_nonidem;
        exec_d    = exec_q | hit_exec;
        cache_d   = cache_q | hit_cache;
        if (idx_q == LastIdx) begin
          state_d = RESP;
          fault_d = is_fetch_q & ~(exec_q | hit_exec);
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        req_ready_o = rsp_ready_i;
        if (rsp_ready_i) begin
          if (req_valid_i) accept = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      accept      = 1'b0;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      state_d     = IDLE;
      idx_d       = '0;
    end

    if (accept) begin
      state_d    = SCAN;
      idx_d      = '0;
      paddr_d    = req_paddr_i;
      is_fetch_d = req_is_fetch_i;
      id_d       = req_id_i;
      nonidem_d  = 1'b0;
      exec_d     = 1'b0;
      cache_d    = 1'b0;
      fault_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      paddr_q    <= '0;
      is_fetch_q <= 1'b0;
      id_q       <= '0;
      nonidem_q  <= 1'b0;
      exec_q     <= 1'b0;
      cache_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      paddr_q    <= paddr_d;
      is_fetch_q <= is_fetch_d;
      id_q       <= id_d;
      nonidem_q  <= nonidem_d;
      exec_q     <= exec_d;
      cache_q    <= cache_d;
      fault_q    <= fault_d;
    end
  end

  assign rsp_paddr_o     = paddr_q;
  assign rsp_id_o        = id_q;
  assign rsp_cacheable_o = cache_q;
  assign rsp_nonidem_o   = nonidem_q;
  assign rsp_exec_o      = exec_q;
  assign rsp_fault_o     = fault_q;

endmodule

// File: tb/tb_pma_scan_unit.sv
// tb/tb_pma_scan_unit.sv - scoreboard bench for pma_scan_unit with default config
module tb_pma_scan_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_paddr_i = '0;
  logic        req_is_fetch_i = 1'b0;
  logic [3:0]  req_id_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [63:0] rsp_paddr_o;
  logic [3:0]  rsp_id_o;
  logic        rsp_cacheable_o, rsp_nonidem_o, rsp_exec_o, rsp_fault_o;

  pma_scan_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr_i),
    .req_is_fetch_i(req_is_fetch_i), .req_id_i(req_id_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_paddr_o(rsp_paddr_o),
    .rsp_id_o(rsp_id_o), .rsp_cacheable_o(rsp_cacheable_o), .rsp_nonidem_o(rsp_nonidem_o),
    .rsp_exec_o(rsp_exec_o), .rsp_fault_o(rsp_fault_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] paddr;
    logic [3:0]  id;
    logic        c, n, e, f;
    int          rise;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  exp_t head;
  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {60'b0, rsp_id_o}, 64'hdead);
      end else begin
        head = sb[0];
        if (!prev_valid || prev_hs) chk("rsp_latency", 64'(cyc), 64'(head.rise));
        chk("rsp_id", {60'b0, rsp_id_o}, {60'b0, head.id});
        chk("rsp_paddr", rsp_paddr_o, head.paddr);
        chk("rsp_cacheable", {63'b0, rsp_cacheable_o}, {63'b0, head.c});
        chk("rsp_nonidem", {63'b0, rsp_nonidem_o}, {63'b0, head.n});
        chk("rsp_exec", {63'b0, rsp_exec_o}, {63'b0, head.e});
        chk("rsp_fault", {63'b0, rsp_fault_o}, {63'b0, head.f});
        if (rsp_ready_i) void'(sb.pop_front());
      end
    end
    prev_valid = rst_ni & rsp_valid_o;
    prev_hs    = rst_ni & rsp_valid_o & rsp_ready_i;
  end

  task automatic push_exp(input logic [63:0] a, input logic [3:0] id,
                          input logic c, input logic n, input logic e, input logic f);
    exp_t x;
    x.paddr = a; x.id = id; x.c = c; x.n = n; x.e = e; x.f = f;
    x.rise = cyc + 4;
    sb.push_back(x);
  endtask

  // Offer a request and wait (bounded) for the handshake; optionally score it.
  task automatic offer(input logic [63:0] a, input logic fetch, input logic [3:0] id,
                       input logic score, input logic c, input logic n, input logic e,
                       input logic f);
    int k;
    req_valid_i = 1'b1; req_paddr_i = a; req_is_fetch_i = fetch; req_id_i = id;
    k = 0;
    @(negedge clk_i);
    while (!req_ready_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    if (!req_ready_o) chk("req_handshake_timeout", 64'd0, 64'd1);
    else if (score) push_exp(a, id, c, n, e, f);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk_i);
      k++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int k;
    // Reset state
    #12;
    chk("reset_rsp_valid", {63'b0, rsp_valid_o}, 64'd0);
    chk("reset_rsp_id", {60'b0, rsp_id_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("reset_req_ready", {63'b0, req_ready_o}, 64'd1);
    @(posedge clk_i); #1;

    // Directed attribute vectors (fields: paddr, fetch, id, score, c, n, e, f)
    offer(64'h8000_1000, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    offer(64'hBFFF_FFFF, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    offer(64'hC000_0000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    offer(64'h0000_0FFF, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    offer(64'h4000_0000, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    offer(64'h0000_1000, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    offer(64'h0001_FFFF, 1'b1, 4'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    offer(64'h0002_0000, 1'b1, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    offer(64'hC000_0000, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    offer(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Backpressure: hold the response for 5 cycles with a queued request
    rsp_ready_i = 1'b0;
    offer(64'h8000_0000, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    k = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("bp_rsp_seen", {63'b0, rsp_valid_o}, 64'd1);
    chk("bp_req_ready", {63'b0, req_ready_o}, 64'd0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_paddr_i = 64'h0001_0000; req_is_fetch_i = 1'b1; req_id_i = 4'd7;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_req_ready", {63'b0, req_ready_o}, 64'd0);
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_ready", {63'b0, req_ready_o}, 64'd1);
    push_exp(64'h0001_0000, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    drain();

    // Flush in the second scan cycle, with a request offered during the flush
    offer(64'h8000_2000, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    req_valid_i = 1'b1; req_paddr_i = 64'h9000_0000; req_is_fetch_i = 1'b0; req_id_i = 4'd9;
    @(negedge clk_i);
    chk("flush_req_ready", {63'b0, req_ready_o}, 64'd0);
    chk("flush_rsp_valid", {63'b0, rsp_valid_o}, 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("post_flush_idle_ready", {63'b0, req_ready_o}, 64'd1);
    push_exp(64'h9000_0000, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    drain();

    // Asynchronous reset in the middle of a scan
    offer(64'h8000_3000, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_rsp_valid", {63'b0, rsp_valid_o}, 64'd0);
    chk("async_rst_rsp_paddr", rsp_paddr_o, 64'd0);
    chk("async_rst_rsp_id", {60'b0, rsp_id_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_req_ready", {63'b0, req_ready_o}, 64'd1);
    chk("post_rst_rsp_valid", {63'b0, rsp_valid_o}, 64'd0);
    @(posedge clk_i); #1;
    offer(64'h0001_0000, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    repeat (4) @(negedge clk_i);
    chk("final_idle_rsp_valid", {63'b0, rsp_valid_o}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pma_scan_unit.md
Name: pma_scan_unit

Overview:
- Sequential PMA attribute stage between MMU translation output and the fetch/LSU cache request path.
- Takes one physical address per transaction and scans the configured non-idempotent, execute and cached region tables one rule index per cycle. This replaces the full parallel compare to save area.
- Returns cacheable, non-idempotent and executable attributes plus a fetch access fault, over a valid/ready interface.

Parameters:
- Cfg, ariane_cfg_pkg::ArianeDefaultConfig, PMA region tables and rule counts (ariane_cfg_t).
- IdWidth, 4, width of the transaction tag passed through unchanged.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort any in-flight transaction
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_paddr_i  in  64  physical address
- req_is_fetch_i  in  1  request is an instruction fetch
- req_id_i  in  IdWidth  transaction tag
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_paddr_o  out  64  captured address
- rsp_id_o  out  IdWidth  captured tag
- rsp_cacheable_o  out  1  address inside any cached region
- rsp_nonidem_o  out  1  address inside any non-idempotent region
- rsp_exec_o  out  1  address inside any execute region
- rsp_fault_o  out  1  req_is_fetch & ~exec

Behaviour:
- Scan length N = max(NrNonIdempotentRules, NrExecuteRegionRules, NrCachedRegionRules, 1), fixed at elaboration.
- Rule index counter width is $clog2(NrMaxRules).
- Rule k matches when paddr >= base[k] and paddr < (base[k]+len[k]). The sum is 64-bit and wraps mod 2^64.
  - Consequence: a region whose end wraps past 2^64 never matches.
  - A zero-length region never matches.
- Rule k of a table is evaluated only when k < that table's rule count.
- A table with zero rules yields attribute 0. With zero execute rules, every fetch faults.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_ready_o=1.
  - On handshake: capture paddr, is_fetch and id; clear the three sticky match flags; index=0; go to SCAN.
- SCAN:
  - req_ready_o=0, rsp_valid_o=0.
  - Each cycle evaluates index k on all three tables and ORs the result into the sticky flags.
  - When k=N-1, go to RESP; otherwise k+1.
- RESP:
  - rsp_valid_o=1. All rsp_* outputs come from registers and hold stable until rsp_ready_i.
  - req_ready_o = rsp_ready_i, giving a back-to-back path.
  - On rsp_ready_i with a new req_valid_i: capture the new request and go to SCAN.
  - On rsp_ready_i with no new request: go to IDLE.
- Latency: request handshake in cycle t gives rsp_valid_o first high in cycle t+N+1. Throughput is one transaction per N+1 cycles.
- flush_i (highest priority):
  - Combinationally forces req_ready_o=0 and rsp_valid_o=0.
  - Next state is IDLE from any state; any captured request or pending response is dropped.
  - A request offered in the flush cycle is not accepted.
- Reset (asynchronous, any state including mid-scan):
  - State=IDLE, index=0, flags=0.
  - rsp_valid_o=0, all rsp_* data outputs=0.
  - req_ready_o=1 while in IDLE after reset is released.
- rsp_fault_o is registered with the other attributes and valid only with rsp_valid_o.
- Non-fetch requests never fault.

Test Plan:
- Default Cfg (N=3): fetch 0x8000_1000, id 5, handshake cycle 0 -> rsp_valid_o rises cycle 4 with cacheable=1, exec=1, nonidem=0, fault=0, id=5.
- Boundaries: fetch 0xBFFF_FFFF -> cacheable=1, exec=1; fetch 0xC000_0000 -> cacheable=0, exec=0, fault=1; load 0x0000_0FFF -> exec=1 (debug region), fault=0.
- Load (is_fetch=0) at 0x4000_0000 -> all attributes 0, fault=0. Nonidem stays 0 for all addresses with the default zero-length rules.
- Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP -> outputs stable, req_ready_o=0. Then raise rsp_ready_i with a queued request -> new request accepted that same cycle, its response arrives 4 cycles later.
- Flush during SCAN cycle 2 -> no response for that id, FSM in IDLE next cycle. A request offered during the flush cycle is not taken, and is taken one cycle later.
- Assert rst_ni low mid-SCAN, asynchronously -> rsp_valid_o=0 immediately. After release, req_ready_o=1 and a new fetch 0x1_0000 returns exec=1, cacheable=0.
